// File: rtl/window_streamer.sv
// Nucleotide stream front end: builds overlapping k-mer windows, drives the hasher handshake and
// tags each window as insert/query. Optional tail padding: WINDOW_STREAMER_TAIL_PAD_EN.
module window_streamer #(
    parameter int unsigned WINDOW_SIZE              = 128,
    parameter int unsigned KMER_SIZE                = 16,
    parameter int unsigned NUCS_PER_BEAT            = 1,
    parameter int unsigned MAX_WINDOWS_IN_REFERENCE = 1024
) (
    input  logic                         clk_i,
    input  logic                         reset_window_streamer_i,
    input  logic                         nuc_valid_i,
    output logic                         nuc_ready_o,
    input  logic [2*NUCS_PER_BEAT-1:0]   nuc_data_i,
    input  logic                         nuc_last_i,
    input  logic                         seq_is_reference_i,
    output logic [WINDOW_SIZE-1:0][1:0]  window_o,
    output logic                         reset_window_hasher_o,
    output logic                         ready_for_hashing_o,
    input  logic                         hashing_is_done_i,
    output logic                         is_insert_o,
    output logic                         is_query_o,
    output logic [31:0]                  window_id_o,
    output logic                         seq_done_o,
    output logic                         ref_overflow_o,
    output logic                         tail_window_o
);

    localparam int unsigned Stride = WINDOW_SIZE - KMER_SIZE + 1;
    localparam int unsigned CntW   = $clog2(WINDOW_SIZE + 1);
    localparam int unsigned BufW   = 2 * WINDOW_SIZE;
    localparam int unsigned BeatW  = 2 * NUCS_PER_BEAT;

    localparam logic [CntW-1:0] WinCnt  = CntW'(WINDOW_SIZE);
    localparam logic [CntW-1:0] KeepCnt = CntW'(KMER_SIZE - 1);
    localparam logic [CntW-1:0] BeatCnt = CntW'(NUCS_PER_BEAT);

    if (KMER_SIZE == 0 || KMER_SIZE > WINDOW_SIZE) begin : g_bad_kmer
        $error("window_streamer: KMER_SIZE must be in 1..WINDOW_SIZE");
    end
    if ((WINDOW_SIZE % NUCS_PER_BEAT) != 0 || (Stride % NUCS_PER_BEAT) != 0) begin : g_bad_npb
        $error("window_streamer: NUCS_PER_BEAT must divide WINDOW_SIZE and the stride");
    end

    typedef enum logic [2:0] {
        StFill,
        StTail,
        StPrep,
        StHash,
        StCommit,
        StDone
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [BufW-1:0]   buf_q;
    logic [31:0]       id_q;
    logic              is_ref_q;
    logic              first_q;
    logic              last_q;
    logic              ready_q;
    logic              rwh_q;
    logic              rfh_q;
    logic              ins_q;
    logic              qry_q;
    logic              done_q;
    logic              ovf_q;

    logic              beat_acc;
    logic [CntW-1:0]   cnt_d;
    logic [BufW-1:0]   buf_d;

    // ready_q is only ever high while in StFill, so it doubles as the state qualifier.
    assign beat_acc = nuc_valid_i & ready_q;
    assign cnt_d    = cnt_q + BeatCnt;
    assign buf_d    = (buf_q >> BeatW) | (BufW'(nuc_data_i) << (BufW - BeatW));

`ifdef WINDOW_STREAMER_TAIL_PAD_EN
    logic            tail_q;
    logic [BufW-1:0] buf_pad;

    // Slide the valid remainder down to index 0; zeros (A) fill the top.
    assign buf_pad       = buf_q >> (2 * (WINDOW_SIZE - 32'(cnt_q)));
    assign tail_window_o = tail_q;
`else
    assign tail_window_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_window_streamer_i) begin
            state_q  <= StFill;
            cnt_q    <= '0;
            buf_q    <= '0;
            id_q     <= '0;
            is_ref_q <= 1'b0;
            first_q  <= 1'b1;
            last_q   <= 1'b0;
            ready_q  <= 1'b0;
            rwh_q    <= 1'b0;
            rfh_q    <= 1'b0;
            ins_q    <= 1'b0;
            qry_q    <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef WINDOW_STREAMER_TAIL_PAD_EN
            tail_q   <= 1'b0;
`endif
        end else begin
            rwh_q  <= 1'b0;
            ins_q  <= 1'b0;
            qry_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StFill: begin
                    ready_q <= 1'b1;
                    if (beat_acc) begin
                        buf_q <= buf_d;
                        cnt_q <= cnt_d;
                        if (first_q) begin
                            first_q  <= 1'b0;
                            is_ref_q <= seq_is_reference_i;
                            id_q     <= '0;
                        end
                        if (cnt_d == WinCnt) begin
                            state_q <= StPrep;
                            ready_q <= 1'b0;
                            rwh_q   <= 1'b1;
                            last_q  <= nuc_last_i;
                        end else if (nuc_last_i) begin
                            state_q <= StTail;
                            ready_q <= 1'b0;
                        end
                    end
                end
                StTail: begin
`ifdef WINDOW_STREAMER_TAIL_PAD_EN
                    if (cnt_q > KeepCnt) begin
                        buf_q   <= buf_pad;
                        state_q <= StPrep;
                        rwh_q   <= 1'b1;
                        tail_q  <= 1'b1;
                        last_q  <= 1'b1;
                    end else begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
`else
                    state_q <= StDone;
                    done_q  <= 1'b1;
`endif
                end
                StPrep: begin
                    state_q <= StHash;
                    rfh_q   <= 1'b1;
                end
                StHash: begin
                    if (hashing_is_done_i) begin
                        state_q <= StCommit;
                        rfh_q   <= 1'b0;
                        if (!is_ref_q) begin
                            qry_q <= 1'b1;
                        end else if (id_q < MAX_WINDOWS_IN_REFERENCE) begin
                            ins_q <= 1'b1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                StCommit: begin
                    id_q <= id_q + 32'd1;
`ifdef WINDOW_STREAMER_TAIL_PAD_EN
                    tail_q <= 1'b0;
`endif
                    if (last_q) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        // Keep the k-1 overlap; the next window needs only a stride of new data.
                        state_q <= StFill;
                        ready_q <= 1'b1;
                        cnt_q   <= KeepCnt;
                    end
                end
                StDone: begin
                    state_q <= StFill;
                    ready_q <= 1'b1;
                    cnt_q   <= '0;
                    first_q <= 1'b1;
                    last_q  <= 1'b0;
                end
                default: begin
                    state_q <= StFill;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign nuc_ready_o           = ready_q;
    assign window_o              = buf_q;
    assign reset_window_hasher_o = rwh_q;
    assign ready_for_hashing_o   = rfh_q;
    assign is_insert_o           = ins_q;
    assign is_query_o            = qry_q;
    assign window_id_o           = id_q;
    assign seq_done_o            = done_q;
    assign ref_overflow_o        = ovf_q;

endmodule

// File: tb/tb_window_streamer.sv
// Directed bench for window_streamer (W=8, K=3, 2 nucleotides/beat); a second instance with a
// reference limit of one window runs in lockstep to exercise the overflow path.
`timescale 1ns/1ps
module tb_window_streamer;

    localparam int unsigned W   = 8;
    localparam int unsigned K   = 3;
    localparam int unsigned NPB = 2;

    logic                 clk = 1'b0;
    logic                 reset_window_streamer;
    logic                 nuc_valid;
    logic [2*NPB-1:0]     nuc_data;
    logic                 nuc_last;
    logic                 seq_is_reference;
    logic                 hashing_is_done;

    logic                 nuc_ready;
    logic [W-1:0][1:0]    window;
    logic                 reset_window_hasher;
    logic                 ready_for_hashing;
    logic                 is_insert;
    logic                 is_query;
    logic [31:0]          window_id;
    logic                 seq_done;
    logic                 ref_overflow;
    logic                 tail_window;

    logic                 b_nuc_ready;
    logic [W-1:0][1:0]    b_window;
    logic                 b_rwh;
    logic                 b_rfh;
    logic                 b_ins;
    logic                 b_qry;
    logic [31:0]          b_window_id;
    logic                 b_done;
    logic                 b_ovf;
    logic                 b_tail;

    logic [2*W-1:0]       win_flat;
    assign win_flat = window;

    always #5 clk = ~clk;

    window_streamer #(
        .WINDOW_SIZE(W), .KMER_SIZE(K), .NUCS_PER_BEAT(NPB), .MAX_WINDOWS_IN_REFERENCE(1024)
    ) dut (
        .clk_i(clk), .reset_window_streamer_i(reset_window_streamer),
        .nuc_valid_i(nuc_valid), .nuc_ready_o(nuc_ready), .nuc_data_i(nuc_data),
        .nuc_last_i(nuc_last), .seq_is_reference_i(seq_is_reference), .window_o(window),
        .reset_window_hasher_o(reset_window_hasher), .ready_for_hashing_o(ready_for_hashing),
        .hashing_is_done_i(hashing_is_done), .is_insert_o(is_insert), .is_query_o(is_query),
        .window_id_o(window_id), .seq_done_o(seq_done), .ref_overflow_o(ref_overflow),
        .tail_window_o(tail_window)
    );

    window_streamer #(
        .WINDOW_SIZE(W), .KMER_SIZE(K), .NUCS_PER_BEAT(NPB), .MAX_WINDOWS_IN_REFERENCE(1)
    ) dut_b (
        .clk_i(clk), .reset_window_streamer_i(reset_window_streamer),
        .nuc_valid_i(nuc_valid), .nuc_ready_o(b_nuc_ready), .nuc_data_i(nuc_data),
        .nuc_last_i(nuc_last), .seq_is_reference_i(seq_is_reference), .window_o(b_window),
        .reset_window_hasher_o(b_rwh), .ready_for_hashing_o(b_rfh),
        .hashing_is_done_i(hashing_is_done), .is_insert_o(b_ins), .is_query_o(b_qry),
        .window_id_o(b_window_id), .seq_done_o(b_done), .ref_overflow_o(b_ovf),
        .tail_window_o(b_tail)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]     ev_kind[$];
    int             ev_id[$];
    logic [2*W-1:0] ev_win[$];
    logic           ev_tail[$];
    logic           lat_q[$];
    int             nb_ins;
    int             nb_qry;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] nuc_code(input byte c);
        case (c)
            8'h43:   return 2'b01;
            8'h47:   return 2'b10;
            8'h54:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [2*W-1:0] str2win(input string s);
        logic [2*W-1:0] w;
        w = '0;
        for (int i = 0; i < s.len() && i < int'(W); i++) w[2*i +: 2] = nuc_code(s[i]);
        return w;
    endfunction

    task automatic drive_beat(input string s, input int idx, input int beats);
        nuc_valid = 1'b1;
        nuc_last  = (idx == beats - 1);
        for (int j = 0; j < int'(NPB); j++) nuc_data[2*j +: 2] = nuc_code(s[idx*NPB + j]);
    endtask

    // Streams one sequence and plays the hasher: hashing_is_done follows `delay` HASH cycles.
    task automatic run_seq(input string s, input bit is_ref, input int delay, input bit stray);
        int beats, idx, cyc, hcnt;
        bit acc, acc_prev, rwh_prev, got_done;
        logic [2*W-1:0] snap;
        beats = s.len() / NPB;
        idx = 0; cyc = 0; hcnt = 0;
        acc_prev = 0; rwh_prev = 0; got_done = 0; snap = '0;
        ev_kind.delete(); ev_id.delete(); ev_win.delete(); ev_tail.delete(); lat_q.delete();
        nb_ins = 0; nb_qry = 0;
        @(posedge clk); #1;
        seq_is_reference = is_ref;
        drive_beat(s, 0, beats);
        while (!got_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            acc = nuc_valid && nuc_ready;
            if (is_insert || is_query) begin
                ev_kind.push_back({is_insert, is_query});
                ev_id.push_back(int'(window_id));
                ev_win.push_back(win_flat);
                ev_tail.push_back(tail_window);
            end
            if (b_ins) nb_ins++;
            if (b_qry) nb_qry++;
            if (reset_window_hasher) lat_q.push_back(acc_prev);
            if (rwh_prev) check_eq("prep_to_hash", ready_for_hashing, 1);
            if (ready_for_hashing) begin
                hcnt++;
                if (delay >= 5) begin
                    if (hcnt == 1) snap = win_flat;
                    else check_eq("window_hold", win_flat, snap);
                    check_eq("ready_in_hash", nuc_ready, 0);
                end
            end else begin
                hcnt = 0;
            end
            if (seq_done) got_done = 1;
            acc_prev = acc;
            rwh_prev = reset_window_hasher;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < beats) drive_beat(s, idx, beats);
                else begin nuc_valid = 1'b0; nuc_last = 1'b0; end
            end
            hashing_is_done = (hcnt == delay) || (stray && cyc == 1);
        end
        hashing_is_done = 1'b0;
        check_eq("seq_done_seen", got_done, 1);
    endtask

    task automatic check_events(input string name, input int n, input logic [1:0] kind,
                                input string w0, input string w1, input bit t1);
        check_eq({name, "_n"}, ev_kind.size(), n);
        for (int i = 0; i < n && i < ev_kind.size(); i++) begin
            check_eq($sformatf("%s_kind%0d", name, i), ev_kind[i], kind);
            check_eq($sformatf("%s_id%0d", name, i), ev_id[i], i);
            check_eq($sformatf("%s_win%0d", name, i), ev_win[i], str2win(i == 0 ? w0 : w1));
            check_eq($sformatf("%s_tail%0d", name, i), ev_tail[i], (i == 1) ? t1 : 1'b0);
        end
        check_eq({name, "_lat0"}, (lat_q.size() > 0) ? lat_q[0] : 1'b0, 1);
    endtask

    initial begin
        string s14, s12;
        int nwin, hcnt, cyc, idx;
        bit found, acc;
        s14 = "ACGTACGTACGTAC";
        s12 = "ACGTTGCAGGCC";
        reset_window_streamer = 1'b1;
        nuc_valid = 1'b0; nuc_data = '0; nuc_last = 1'b0;
        seq_is_reference = 1'b0; hashing_is_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", nuc_ready, 0);
        check_eq("rst_window", win_flat, 0);
        check_eq("rst_flags", {reset_window_hasher, ready_for_hashing, is_insert, is_query,
                               seq_done, ref_overflow, tail_window}, 0);
        check_eq("rst_id", window_id, 0);
        reset_window_streamer = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", nuc_ready, 1);

        // Reference: two inserts; the limit-1 instance inserts once then overflows.
        run_seq(s14, 1'b1, 1, 1'b0);
        check_events("ref", 2, 2'b10, "ACGTACGT", "GTACGTAC", 1'b0);
        check_eq("ref_lat1", (lat_q.size() > 1) ? lat_q[1] : 1'b0, 1);
        check_eq("ref_ovf_main", ref_overflow, 0);
        check_eq("b_ins_count", nb_ins, 1);
        check_eq("b_ovf", b_ovf, 1);

        // Read with a stray done pulse while filling.
        run_seq(s14, 1'b0, 1, 1'b1);
        check_events("read", 2, 2'b01, "ACGTACGT", "GTACGTAC", 1'b0);
        check_eq("b_qry_count", nb_qry, 2);
        check_eq("b_ovf_sticky", b_ovf, 1);

        // Slow hasher: window and backpressure must hold through HASH.
        run_seq(s14, 1'b0, 10, 1'b0);
        check_events("slow", 2, 2'b01, "ACGTACGT", "GTACGTAC", 1'b0);

        // 12 nucleotides: remainder of 6 after the first window.
        run_seq(s12, 1'b1, 2, 1'b0);
`ifdef WINDOW_STREAMER_TAIL_PAD_EN
        check_events("tail", 2, 2'b10, "ACGTTGCA", "CAGGCCAA", 1'b1);
`else
        check_events("tail", 1, 2'b10, "ACGTTGCA", "", 1'b0);
`endif

        // Reset in the middle of hashing the second window of a read.
        nwin = 0; hcnt = 0; cyc = 0; idx = 0; found = 0;
        @(posedge clk); #1;
        seq_is_reference = 1'b0;
        drive_beat(s14, 0, 7);
        while (!found && cyc < 100) begin
            @(negedge clk);
            cyc++;
            acc = nuc_valid && nuc_ready;
            if (is_query) nwin++;
            if (ready_for_hashing) begin
                if (nwin == 1) found = 1;
                else hcnt++;
            end else begin
                hcnt = 0;
            end
            if (!found) begin
                @(posedge clk); #1;
                if (acc) begin
                    idx++;
                    if (idx < 7) drive_beat(s14, idx, 7);
                    else begin nuc_valid = 1'b0; nuc_last = 1'b0; end
                end
                hashing_is_done = (hcnt == 1);
            end
        end
        check_eq("hash2_reached", found, 1);
        check_eq("id_before_reset", window_id, 1);
        reset_window_streamer = 1'b1;
        nuc_valid = 1'b0; nuc_last = 1'b0; hashing_is_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_flags", {reset_window_hasher, ready_for_hashing, is_insert, is_query,
                                   seq_done, ref_overflow, tail_window, nuc_ready}, 0);
        check_eq("mid_rst_window", win_flat, 0);
        check_eq("mid_rst_id", window_id, 0);
        check_eq("b_rst_all", {b_window, b_rwh, b_rfh, b_ins, b_qry, b_done, b_ovf, b_tail,
                               b_nuc_ready}, 0);
        check_eq("b_rst_id", b_window_id, 0);
        reset_window_streamer = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", nuc_ready, 1);
        check_eq("post_rst_rfh", ready_for_hashing, 0);
        check_eq("post_rst_id", window_id, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_streamer.md
Name: window_streamer

Overview:
- Synthesisable, parametrised front end for the LSH sketching pipeline.
- Accepts a nucleotide stream over a valid/ready interface, several 2-bit nucleotides per beat.
- Builds overlapping windows that share KMER_SIZE-1 nucleotides, drives the window_hasher handshake, then pulses is_insert (reference sequence) or is_query (read sequence) to hash_table with a per-sequence window_id.

Parameters:
- WINDOW_SIZE, 128, nucleotides per window.
- KMER_SIZE, 16, k-mer length; consecutive windows overlap by KMER_SIZE-1.
- NUCS_PER_BEAT, 1, nucleotides per input beat. Must divide both WINDOW_SIZE and STRIDE = WINDOW_SIZE-KMER_SIZE+1; checked at elaboration.
- MAX_WINDOWS_IN_REFERENCE, 1024, maximum number of reference windows that can be inserted.

Ports:
- clk  in  1  clock.
- reset_window_streamer  in  1  synchronous, active-high reset.
- nuc_valid  in  1  input beat valid.
- nuc_ready  out  1  input beat accepted when nuc_valid && nuc_ready.
- nuc_data  in  2*NUCS_PER_BEAT  nucleotides; bits [1:0] are the earliest. Encoding A=00, C=01, G=10, T=11.
- nuc_last  in  1  marks the final beat of a sequence.
- seq_is_reference  in  1  sampled on the first accepted beat of each sequence.
- window  out  WINDOW_SIZE x 2  current window; window[0] is the oldest nucleotide.
- reset_window_hasher  out  1  one-cycle pulse before each window is hashed.
- ready_for_hashing  out  1  window valid and stable.
- hashing_is_done  in  1  one-cycle pulse from window_hasher.
- is_insert  out  1  one-cycle pulse.
- is_query  out  1  one-cycle pulse.
- window_id  out  32  index of the current window within its sequence.
- seq_done  out  1  one-cycle pulse after a sequence is fully processed.
- ref_overflow  out  1  sticky flag: reference window count exceeded the limit.
- tail_window  out  1  current window is zero-padded (feature only; otherwise 0).

Behaviour:
- Reset values:
  - All outputs 0, window all 00, nuc_ready 0.
  - State FILL, fill count 0, window_id 0, ref_overflow 0.
  - Reset aborts any operation in progress, including mid-HASH.
- Buffer:
  - Shift register of WINDOW_SIZE entries.
  - Each accepted beat shifts toward index 0 by NUCS_PER_BEAT; new nucleotides enter at the top indices, in order.
  - window is driven directly from the buffer.
- FILL:
  - nuc_ready=1.
  - Fill count adds NUCS_PER_BEAT per accepted beat.
  - Go to PREP when the count reaches WINDOW_SIZE.
  - Go to PREP when nuc_last is accepted with count < WINDOW_SIZE and no window has been emitted yet in this sequence? No: go to TAIL in that case (see below).
  - The first beat of a sequence latches seq_is_reference into is_ref and clears window_id to 0.
  - ref_overflow is not cleared per sequence.
- TAIL: when nuc_last is accepted with count < WINDOW_SIZE, go to TAIL.
  - The partial window is discarded.
  - seq_done pulses, then the block returns to FILL with count 0.
- PREP: reset_window_hasher=1 for exactly one cycle, then go to HASH.
- HASH:
  - ready_for_hashing=1 and nuc_ready=0; window is held constant.
  - Wait any number of cycles for hashing_is_done, then go to COMMIT.
  - A hashing_is_done pulse seen outside HASH is ignored.
- COMMIT (one cycle):
  - If is_ref and window_id < MAX_WINDOWS_IN_REFERENCE: is_insert=1.
  - If is_ref and window_id >= MAX_WINDOWS_IN_REFERENCE: no pulse, and ref_overflow is set.
  - If not is_ref: is_query=1.
  - window_id is held during COMMIT and increments on the following cycle (32-bit wrap).
  - Fill count becomes KMER_SIZE-1, so the overlap is retained in the buffer.
  - If the last beat has already been consumed, pulse seq_done in the next cycle and reset count to 0.
  - Otherwise return to FILL.
- A new window therefore requires STRIDE fresh nucleotides.
- Latency: last needed beat accepted at cycle t gives reset_window_hasher at t+1 and ready_for_hashing from t+2.
- nuc_last on a beat that exactly completes a window: that window is processed normally, then seq_done.

Optional Feature:
- Macro WINDOW_STREAMER_TAIL_PAD_EN.
- When defined: in TAIL, a sequence remainder with more than KMER_SIZE-1 valid nucleotides is zero-padded (A) up to WINDOW_SIZE. It goes through PREP/HASH/COMMIT with tail_window=1 for PREP through COMMIT, then seq_done. A remainder of KMER_SIZE-1 or fewer is discarded.
- When undefined: all partial tails are discarded and tail_window is tied to 0.

Test Plan:
- Config W=8, K=3, NPB=2, reference of 14 nucleotides ACGTACGTACGTAC -> two windows: "ACGTACGT" (id 0) and "GTACGTAC" (id 1). Each gives an is_insert pulse; then seq_done.
- Same config as a read -> is_query pulses with ids 0 and 1; no is_insert.
- hashing_is_done delayed 10 cycles -> window stable and nuc_ready=0 throughout HASH; no input accepted.
- MAX_WINDOWS_IN_REFERENCE=1 with a reference yielding 2 windows -> one is_insert, then ref_overflow=1 and no second pulse.
- 12-nucleotide sequence (remainder of 6 after the first window) -> without the macro: one window, then seq_done. With WINDOW_STREAMER_TAIL_PAD_EN: a second window ending in "AA", tail_window=1.
- Reset asserted mid-HASH -> next cycle all outputs 0, state FILL, window_id 0, nuc_ready 1 the cycle after reset deasserts.
